// File: rtl/iob_reset_seq_pkg.sv
// Shared types and helpers for the iob_reset_seq reset sequencer.
// State encoding is visible on state_o, so it must stay 0..3 as listed.
package iob_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    // Width of a down-counter that must hold the larger of two loads.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/iob_reset_seq_if.sv
// Readiness / reset bundle between FPGA wrapper glue and iob_reset_seq.
// timeout_o exists only when IOB_RESET_SEQ_WDT_EN is defined.
interface iob_reset_seq_if #(
    parameter int N_READY = 2,
    parameter int N_OUT   = 3
) ();

    logic [N_READY-1:0] ready_i;
    logic               soft_rst_i;
    logic [N_OUT-1:0]   rst_o;
    logic               all_released_o;
    logic [1:0]         state_o;
    logic               fault_o;
`ifdef IOB_RESET_SEQ_WDT_EN
    logic               timeout_o;
`endif

    modport master (
        output ready_i, soft_rst_i,
        input  rst_o, all_released_o, state_o, fault_o
`ifdef IOB_RESET_SEQ_WDT_EN
        , input timeout_o
`endif
    );

    modport slave (
        input  ready_i, soft_rst_i,
        output rst_o, all_released_o, state_o, fault_o
`ifdef IOB_RESET_SEQ_WDT_EN
        , output timeout_o
`endif
    );

endinterface

// File: rtl/iob_reset_seq_sync.sv
// Single-bit flop-chain synchronizer with synchronous clear.
// STAGES must be at least 2.
module iob_reset_seq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_ff;

    // Shift the asynchronous input through the chain; rst_i clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ff <= '0;
        end else begin
            r_ff <= {r_ff[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_ff[STAGES-1];

endmodule

// File: rtl/iob_reset_seq.sv
// Reset sequencer: qualifies readiness inputs, then releases N_OUT resets in order.
// Optional HOLD watchdog enabled by defining IOB_RESET_SEQ_WDT_EN.
module iob_reset_seq
    import iob_reset_seq_pkg::*;
#(
    parameter int                 N_READY     = 2,
    parameter logic [N_READY-1:0] READY_MASK  = {N_READY{1'b1}},
    parameter int                 N_OUT       = 3,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 STRETCH     = 16,
    parameter int                 STEP        = 4
`ifdef IOB_RESET_SEQ_WDT_EN
    ,
    parameter int                 WDT_CYCLES  = 1000000
`endif
) (
    input logic              clk_i,
    input logic              rst_i,
    iob_reset_seq_if.slave   bus
);

    localparam int             CW         = cnt_width(STRETCH, STEP);
    localparam int             KW         = $clog2(N_OUT + 1);
    localparam logic [CW-1:0]  STRETCH_LD = CW'(STRETCH);
    localparam logic [CW-1:0]  STEP_LD    = CW'(STEP - 1);
    localparam logic [KW-1:0]  K_LAST     = KW'(N_OUT - 1);

    logic [N_READY-1:0] w_ready_s;
    logic               w_all_rdy;
    logic               w_abort;
    logic               w_fault_set;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [KW-1:0]      r_k;
    logic [KW-1:0]      w_k_nxt;
    logic [N_OUT-1:0]   r_rst;
    logic [N_OUT-1:0]   w_rst_nxt;
    logic               r_released;
    logic               r_fault;

    for (genvar g = 0; g < N_READY; g++) begin : g_sync
        iob_reset_seq_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (bus.ready_i[g]),
            .q_o   (w_ready_s[g])
        );
    end

    // Masked-off inputs count as permanently ready.
    assign w_all_rdy   = &(w_ready_s | ~READY_MASK);
    assign w_abort     = !w_all_rdy || bus.soft_rst_i;
    assign w_fault_set = !w_all_rdy &&
                         (r_state == ST_RELEASE || r_state == ST_RUN);

    // State, counters and reset outputs all registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_HOLD;
            r_cnt      <= '0;
            r_k        <= '0;
            r_rst      <= '1;
            r_released <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_k        <= w_k_nxt;
            r_rst      <= w_rst_nxt;
            r_released <= (w_state_nxt == ST_RUN);
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Next-state decode; any abort collapses straight back to HOLD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HOLD: begin
                if (w_all_rdy) w_state_nxt = ST_STRETCH;
            end
            ST_STRETCH: begin
                if (w_abort) begin
                    w_state_nxt = ST_HOLD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = (N_OUT == 1) ? ST_RUN : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (w_abort) begin
                    w_state_nxt = ST_HOLD;
                end else if (r_cnt == '0 && r_k == K_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_abort) w_state_nxt = ST_HOLD;
            end
            default: w_state_nxt = ST_HOLD;
        endcase
    end

    // Next counter, index and reset-vector values for each state.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_k_nxt   = r_k;
        w_rst_nxt = r_rst;
        case (r_state)
            ST_HOLD: begin
                w_rst_nxt = '1;
                w_cnt_nxt = STRETCH_LD;
                w_k_nxt   = KW'(1);
            end
            ST_STRETCH: begin
                if (w_abort) begin
                    w_rst_nxt = '1;
                end else if (r_cnt == '0) begin
                    w_rst_nxt[0] = 1'b0;
                    w_cnt_nxt    = STEP_LD;
                    w_k_nxt      = KW'(1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_RELEASE: begin
                if (w_abort) begin
                    w_rst_nxt = '1;
                end else if (r_cnt == '0) begin
                    for (int i = 0; i < N_OUT; i++) begin
                        if (KW'(i) == r_k) w_rst_nxt[i] = 1'b0;
                    end
                    w_cnt_nxt = STEP_LD;
                    w_k_nxt   = r_k + KW'(1);
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ST_RUN: begin
                w_rst_nxt = w_abort ? '1 : '0;
            end
            default: w_rst_nxt = '1;
        endcase
    end

    assign bus.rst_o          = r_rst;
    assign bus.all_released_o = r_released;
    assign bus.state_o        = r_state;
    assign bus.fault_o        = r_fault;

`ifdef IOB_RESET_SEQ_WDT_EN
    localparam int            WW       = $clog2(WDT_CYCLES + 1);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
    localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_CYCLES);

    logic [WW-1:0] r_wdt;
    logic          r_timeout;

    // Count HOLD cycles; timeout is sticky and never changes the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wdt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state != ST_HOLD) begin
            r_wdt <= '0;
        end else begin
            if (r_wdt != WDT_MAX) r_wdt <= r_wdt + WW'(1);
            if (r_wdt == WDT_LAST) r_timeout <= 1'b1;
        end
    end

    assign bus.timeout_o = r_timeout;
`endif

endmodule
